vmx_result_drain: RTL and testbench

Downstream drain stage for the VMX systolic-array wrapper. It captures the 128-bit result words the wrapper emits during its export phase (write strobe, address, data), buffers them in a small FIFO, and requantizes each signed 32-bit lane to 8 bits with rounding shift and saturation. It presents packed results on a valid/ready stream toward the DMA/writeback path. The wrapper export cannot be stalled, so the block absorbs bursts and reports drops instead of back-pressuring.

---
 rtl/vmx_result_drain_if.sv | 27 ++
 rtl/vmx_result_drain.sv | 183 ++++++++++++++++++
 tb/tb_vmx_result_drain.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vmx_result_drain_if.sv
// Result stream bundle for the VMX drain stage: capture strobe side from the
// systolic wrapper plus the valid/ready output stream toward writeback.
interface vmx_result_drain_if #(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 32
);
    logic                        wr_en;
    logic [7:0]                  addr;
    logic [LANES*LANE_WIDTH-1:0] d_i;
    logic [LANES*8-1:0]          m_data;
    logic [7:0]                  m_addr;
    logic                        m_valid;
    logic                        m_ready;
    logic                        m_last;

    // Drain stage side: consumes captures, produces the packed stream.
    modport slave (
        input  wr_en, addr, d_i, m_ready,
        output m_data, m_addr, m_valid, m_last
    );

    // Environment side: drives captures and downstream ready.
    modport master (
        output wr_en, addr, d_i, m_ready,
        input  m_data, m_addr, m_valid, m_last
    );
endinterface

// File: rtl/vmx_result_drain.sv
// VMX result drain: captures unstallable export words into a small FIFO,
// requantizes each signed lane to 8 bits (round-half-up shift + clamp) and
// streams packed beats out with valid/ready. Overflow drops are flagged.

// One lane of the requantizer: rounding arithmetic shift then clamp.
module vmx_rd_lane #(
    parameter int LANE_WIDTH = 32
) (
    input  logic [LANE_WIDTH-1:0] v,
    input  logic [4:0]            shift,
    input  logic                  relu_en,
    output logic [7:0]            q,
    output logic                  sat
);
    // Two guard bits so adding the rounding half to the max lane can't wrap.
    localparam int W = LANE_WIDTH + 2;
    localparam logic signed [W-1:0] S_MIN = W'(-128);
    localparam logic signed [W-1:0] S_MAX = W'(127);
    localparam logic signed [W-1:0] U_MAX = W'(255);
    localparam logic signed [W-1:0] ZERO  = '0;

    logic signed [W-1:0] ext, rnd, r;
    logic        [W-1:0] half;

    // Round, shift and saturate to the selected 8-bit range.
    always_comb begin
        ext  = {{2{v[LANE_WIDTH-1]}}, v};
        half = W'(1) << (shift - 5'd1);
        rnd  = ext + $signed(half);
        r    = (shift == 5'd0) ? ext : (rnd >>> shift);
        q    = r[7:0];
        sat  = 1'b0;
        if (relu_en) begin
            if (r < ZERO) begin
                q = 8'h00; sat = 1'b1;
            end else if (r > U_MAX) begin
                q = 8'hFF; sat = 1'b1;
            end
        end else begin
            if (r < S_MIN) begin
                q = 8'h80; sat = 1'b1;
            end else if (r > S_MAX) begin
                q = 8'h7F; sat = 1'b1;
            end
        end
    end
endmodule

module vmx_result_drain #(
    parameter int LANES          = 4,
    parameter int LANE_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int BEATS_PER_TILE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    vmx_result_drain_if.slave             bus,
    input  logic [4:0]                    shift,
    input  logic                          relu_en,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          sat
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
    localparam logic [PW:0]   LVL_FULL  = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_TILE - 1);

    typedef struct packed {
        logic [7:0]                  addr;
        logic [LANES*LANE_WIDTH-1:0] data;
    } entry_t;

    entry_t                   mem_q [FIFO_DEPTH];
    entry_t                   mem_d [FIFO_DEPTH];
    entry_t                   head;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]              level_q, level_d;
    logic [LANES-1:0][7:0]    m_data_q, m_data_d;
    logic [7:0]               m_addr_q, m_addr_d;
    logic                     m_valid_q, m_valid_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic                     ovf_q, ovf_d, sat_q, sat_d;
    logic [LANES-1:0][7:0]    lane_q;
    logic [LANES-1:0]         lane_sat;
    logic                     pop, push, drop, hs;

    assign head = mem_q[rd_ptr_q];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vmx_rd_lane #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
            .v       (head.data[k*LANE_WIDTH +: LANE_WIDTH]),
            .shift   (shift),
            .relu_en (relu_en),
            .q       (lane_q[k]),
            .sat     (lane_sat[k])
        );
    end

    // Handshake qualifiers; a full FIFO still accepts when it pops this cycle.
    always_comb begin
        hs   = m_valid_q && bus.m_ready;
        pop  = (level_q != '0) && (!m_valid_q || bus.m_ready);
        push = bus.wr_en && ((level_q != LVL_FULL) || pop);
        drop = bus.wr_en && !push;
    end

    // Next state: clr wipes everything; otherwise FIFO, output reg, flags.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        m_data_d  = m_data_q;
        m_addr_d  = m_addr_q;
        m_valid_d = m_valid_q;
        beat_d    = beat_q;
        ovf_d     = ovf_q;
        sat_d     = sat_q;
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            m_valid_d = 1'b0;
            beat_d    = '0;
            ovf_d     = 1'b0;
            sat_d     = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{addr: bus.addr, data: bus.d_i};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                m_data_d  = lane_q;
                m_addr_d  = head.addr;
                m_valid_d = 1'b1;
                sat_d     = sat_q | (|lane_sat);
            end else if (hs) begin
                m_valid_d = 1'b0;
            end
            if (hs) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
            if (drop) ovf_d = 1'b1;
            level_d = level_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            m_data_q  <= '0;
            m_addr_q  <= '0;
            m_valid_q <= 1'b0;
            beat_q    <= '0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            m_data_q  <= m_data_d;
            m_addr_q  <= m_addr_d;
            m_valid_q <= m_valid_d;
            beat_q    <= beat_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.m_data  = m_data_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = (beat_q == LAST_BEAT);
    assign level       = level_q;
    assign ovf         = ovf_q;
    assign sat         = sat_q;
endmodule

// File: tb/tb_vmx_result_drain.sv
// Directed bench for vmx_result_drain: reset, latency, requant/ReLU,
// backpressure with overflow, full+pop, and clr behaviour.
module tb_vmx_result_drain;
    logic       clk, rst_n, clr, relu_en, ovf, sat;
    logic [4:0] shift;
    logic [2:0] level;
    int         n_vec, n_err;

    vmx_result_drain_if #(.LANES(4), .LANE_WIDTH(32)) bus ();

    vmx_result_drain #(
        .LANES(4), .LANE_WIDTH(32), .FIFO_DEPTH(4), .BEATS_PER_TILE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus),
        .shift(shift), .relu_en(relu_en),
        .level(level), .ovf(ovf), .sat(sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    function automatic logic [127:0] lanes(input int a);
        return mk(a, a, a, a);
    endfunction

    task automatic push(input logic [7:0] a, input logic [127:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.d_i   = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    // Expects m_ready=1; collects n beats with consecutive addresses.
    task automatic drain(input int n, input logic [7:0] base, input int last_k, input string tag);
        int k;
        logic [7:0] ea;
        k = 0;
        for (int c = 0; c < 20 && k < n; c++) begin
            if (bus.m_valid) begin
                ea = 8'(base + k);
                chk({tag, "_addr"}, bus.m_addr, ea);
                chk({tag, "_data"}, bus.m_data, {4{ea}});
                chk({tag, "_last"}, bus.m_last, (k == last_k));
                k++;
            end
            step();
        end
        chk({tag, "_cnt"}, k, n);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; clr = 1'b0; shift = '0; relu_en = 1'b0;
        bus.wr_en = 1'b0; bus.addr = '0; bus.d_i = '0; bus.m_ready = 1'b0;
        repeat (2) step();
        chk("rst_data", bus.m_data, 0);
        chk("rst_addr", bus.m_addr, 0);
        chk("rst_vld", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_lvl", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        step();

        // Reset asserted mid-stream, between edges
        push(8'h10, lanes(1));
        push(8'h11, lanes(2));
        chk("pre_rst_vld", bus.m_valid, 1);
        chk("pre_rst_lvl", level, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", bus.m_valid, 0);
        chk("mid_rst_lvl", level, 0);
        chk("mid_rst_addr", bus.m_addr, 0);
        chk("mid_rst_data", bus.m_data, 0);
        step(); step();
        #2 rst_n = 1'b1;
        step();

        // Two-edge latency with free output
        bus.m_ready = 1'b1;
        push(8'h21, mk(1, 2, 3, 4));
        chk("lat_e0_vld", bus.m_valid, 0);
        step();
        chk("lat_e1_vld", bus.m_valid, 1);
        chk("lat_e1_addr", bus.m_addr, 8'h21);
        chk("lat_e1_data", bus.m_data, 32'h04030201);
        chk("lat_sat", sat, 0);
        step();
        chk("lat_done_vld", bus.m_valid, 0);

        // Rounding shift with signed saturation
        shift = 5'd2;
        push(8'h30, mk(300, -300, 32'h7FFF_FFFF, 6));
        step();
        chk("rq_data", bus.m_data, 32'h027FB54B);
        chk("rq_sat", sat, 1);
        step();
        shift = 5'd0;
        clr = 1'b1; step(); clr = 1'b0;
        chk("rq_clr_sat", sat, 0);

        // ReLU clamp
        relu_en = 1'b1;
        push(8'h31, mk(-5, 100, 512, 255));
        step();
        chk("relu_data", bus.m_data, 32'hFFFF6400);
        chk("relu_sat", sat, 1);
        step();
        relu_en = 1'b0;

        // Backpressure: 6 words into depth 4 plus output register
        clr = 1'b1; step(); clr = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i), lanes(i));
        chk("bp_lvl4", level, 4);
        chk("bp_ovf0", ovf, 0);
        push(8'd5, lanes(5));
        chk("bp_ovf1", ovf, 1);
        chk("bp_lvl_hold", level, 4);
        chk("bp_head", bus.m_addr, 0);
        bus.m_ready = 1'b1;
        drain(5, 8'h00, 3, "bp");
        chk("bp_empty_vld", bus.m_valid, 0);
        chk("bp_empty_lvl", level, 0);

        // Full FIFO with simultaneous pop accepts the word
        clr = 1'b1; step(); clr = 1'b0;
        chk("fp_clr_ovf", ovf, 0);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), lanes(8'h40 + i));
        chk("fp_lvl_full", level, 4);
        bus.m_ready = 1'b1;
        push(8'h45, lanes(8'h45));
        chk("fp_lvl_hold", level, 4);
        chk("fp_ovf", ovf, 0);
        chk("fp_head", bus.m_addr, 8'h41);
        drain(5, 8'h41, 2, "fp");

        // clr with level=3, output valid, sat set, and a wr_en in the clr cycle
        clr = 1'b1; step(); clr = 1'b0;
        bus.m_ready = 1'b0;
        push(8'h50, lanes(1000));
        push(8'h51, lanes(1));
        push(8'h52, lanes(2));
        push(8'h53, lanes(3));
        chk("cl_pre_lvl", level, 3);
        chk("cl_pre_vld", bus.m_valid, 1);
        chk("cl_pre_sat", sat, 1);
        clr = 1'b1;
        bus.wr_en = 1'b1; bus.addr = 8'h5F; bus.d_i = lanes(7);
        step();
        clr = 1'b0; bus.wr_en = 1'b0;
        chk("cl_lvl", level, 0);
        chk("cl_vld", bus.m_valid, 0);
        chk("cl_ovf", ovf, 0);
        chk("cl_sat", sat, 0);
        step();
        chk("cl_disc_vld", bus.m_valid, 0);
        chk("cl_disc_lvl", level, 0);
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i), lanes(8'h60 + i));
        bus.m_ready = 1'b1;
        drain(4, 8'h60, 3, "cl");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
